multi_chan_counter: RTL

//  Parametrised bank of CHANNELS independent up/down counters, WIDTH bits each.

---
 rtl/multi_chan_counter.sv | 105 ++++++++++
 1 files changed

// File: rtl/multi_chan_counter.sv
// -----------------------------------------------------------------------------
// multi_chan_counter
//   Bank of CHANNELS independent WIDTH-bit up/down counters. Each channel has
//   its own enable, direction and synchronous load; a shared synchronous clear
//   zeroes every channel. Counting either wraps or saturates at the limits
//   0 and MAX_VAL. A one-cycle terminal-count pulse is produced per channel
//   whenever an enabled edge finds the channel at its limit in the count
//   direction, plus a registered OR of all those pulses.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (count, tc, any_tc -> 0)
//   clr       in   synchronous clear, all channels (highest priority)
//   en        in   [CHANNELS]        per-channel count enable
//   up_dn     in   [CHANNELS]        1: count up, 0: count down
//   load      in   [CHANNELS]        per-channel synchronous load strobe
//   load_val  in   [CHANNELS*WIDTH]  load values, channel i at [i*WIDTH +: WIDTH]
//   count     out  [CHANNELS*WIDTH]  registered counts, same packing
//   tc        out  [CHANNELS]        registered terminal-count pulse
//   any_tc    out  registered OR of the per-channel tc next-state values
// -----------------------------------------------------------------------------
module multi_chan_counter #(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  parameter int MAX_VAL  = (1 << WIDTH) - 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       up_dn,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic                      any_tc
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
  localparam logic             SAT_C  = (SATURATE != 0);

  logic [CHANNELS*WIDTH-1:0] count_q, count_d;
  logic [CHANNELS-1:0]       tc_q, tc_d;
  logic                      any_tc_q, any_tc_d;

  // Per-channel next-state: clr > load > en > hold.
  always_comb begin
    count_d  = count_q;
    tc_d     = {CHANNELS{1'b0}};
    any_tc_d = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr) begin
        count_d[i*WIDTH +: WIDTH] = ZERO_C;
      end else if (load[i]) begin
        // Out-of-range load values clamp to the limit rather than truncate.
        if (load_val[i*WIDTH +: WIDTH] > MAX_C) begin
          count_d[i*WIDTH +: WIDTH] = MAX_C;
        end else begin
          count_d[i*WIDTH +: WIDTH] = load_val[i*WIDTH +: WIDTH];
        end
      end else if (en[i]) begin
        if (up_dn[i]) begin
          if (count_q[i*WIDTH +: WIDTH] == MAX_C) begin
            tc_d[i] = 1'b1;
            count_d[i*WIDTH +: WIDTH] = SAT_C ? MAX_C : ZERO_C;
          end else begin
            count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH] + ONE_C;
          end
        end else begin
          if (count_q[i*WIDTH +: WIDTH] == ZERO_C) begin
            tc_d[i] = 1'b1;
            count_d[i*WIDTH +: WIDTH] = SAT_C ? ZERO_C : MAX_C;
          end else begin
            count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH] - ONE_C;
          end
        end
      end else begin
        count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH];
      end
    end
    // Summary is taken from next-state so it lines up with tc.
    any_tc_d = |tc_d;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= {(CHANNELS*WIDTH){1'b0}};
      tc_q     <= {CHANNELS{1'b0}};
      any_tc_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      tc_q     <= tc_d;
      any_tc_q <= any_tc_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign any_tc = any_tc_q;

endmodule
